// File: rtl/flex_pts_tx.sv
// flex_pts_tx -- framed parallel-to-serial transmitter.
//
// Takes a NUM_BITS word through a valid/ready handshake and sends it one
// bit per shift_enable strobe, MSB- or LSB-first. A word may be loaded on
// the strobe that consumes the final bit of the current frame, so frames
// can run back-to-back with no idle bit between them.
//
// Optional feature: define FLEX_PTS_TX_PARITY_EN to append an even-parity
// bit (^data) after the data bits (frame = NUM_BITS+1 strobes). Without
// the macro there is no PARITY state and no parity register.
//
// Parameters:
//   NUM_BITS  data word width (2..32)
//   SHIFT_MSB 1 = MSB first, 0 = LSB first
//   IDLE_VAL  idle line level, also the fill bit shifted into the register
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   shift_enable bit strobe, one bit consumed per high cycle
//   parallel_in  word to transmit, sampled only on accept
//   load_valid   producer offers a word
//   load_ready   word accepted this cycle (combinational on shift_enable)
//   serial_out   current line bit (registered state only)
//   busy         a frame is in progress
//   done         one-cycle pulse after the last bit of a frame is consumed
module flex_pts_tx #(
  parameter int   NUM_BITS  = 8,
  parameter bit   SHIFT_MSB = 1'b1,
  parameter logic IDLE_VAL  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  input  logic                load_valid,
  output logic                load_ready,
  output logic                serial_out,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

`ifdef FLEX_PTS_TX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
`endif

  state_t              state_reg;
  state_t              state_next;
  logic [NUM_BITS-1:0] shreg_reg;
  logic [NUM_BITS-1:0] shreg_shifted;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic                done_reg;
`ifdef FLEX_PTS_TX_PARITY_EN
  logic                par_bit_reg;
`endif

  logic last_data;   // SHIFT state sitting on the final data bit
  logic frame_end;   // strobe that consumes the final bit of the frame
  logic shift_step;  // strobe that consumes a data bit
  logic accept;

  assign last_data  = (state_reg == ST_SHIFT) && (bit_cnt_reg == LAST_CNT);
  assign shift_step = shift_enable && (state_reg == ST_SHIFT);

`ifdef FLEX_PTS_TX_PARITY_EN
  assign frame_end = shift_enable && (state_reg == ST_PARITY);
`else
  assign frame_end = shift_enable && last_data;
`endif

  // Ready is held low during reset so nothing is captured while the
  // register file is being cleared.
  assign load_ready = ~rst & ((state_reg == ST_IDLE) | frame_end);
  assign accept     = load_valid & load_ready;

  // Shifted copy of the register: every bit moves one place toward the
  // output end and the far end fills with the idle level.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BITS; gi++) begin : g_shift
      if (SHIFT_MSB) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shreg_shifted[gi] = IDLE_VAL;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == NUM_BITS - 1) begin : g_fill
          assign shreg_shifted[gi] = IDLE_VAL;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi+1];
        end
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_enable && last_data) begin
`ifdef FLEX_PTS_TX_PARITY_EN
          state_next = ST_PARITY;
`else
          // A word accepted on the final strobe starts the next frame.
          state_next = accept ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef FLEX_PTS_TX_PARITY_EN
      ST_PARITY: begin
        if (shift_enable) begin
          state_next = accept ? ST_SHIFT : ST_IDLE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: shift register, bit counter, parity, done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_reg   <= {NUM_BITS{IDLE_VAL}};
      bit_cnt_reg <= '0;
      done_reg    <= 1'b0;
`ifdef FLEX_PTS_TX_PARITY_EN
      par_bit_reg <= 1'b0;
`endif
    end else begin
      done_reg <= frame_end;
      if (accept) begin
        // A reload wins over the shift of the final data bit.
        shreg_reg   <= parallel_in;
        bit_cnt_reg <= '0;
`ifdef FLEX_PTS_TX_PARITY_EN
        par_bit_reg <= ^parallel_in;
`endif
      end else if (shift_step) begin
        shreg_reg <= shreg_shifted;
        // Counter saturates on the last data bit rather than wrapping.
        if (bit_cnt_reg != LAST_CNT) begin
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  // Output logic: all outputs except load_ready come from registers only.
  always_comb begin
    serial_out = IDLE_VAL;
    busy       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        serial_out = IDLE_VAL;
        busy       = 1'b0;
      end
      ST_SHIFT: begin
        serial_out = SHIFT_MSB ? shreg_reg[NUM_BITS-1] : shreg_reg[0];
        busy       = 1'b1;
      end
`ifdef FLEX_PTS_TX_PARITY_EN
      ST_PARITY: begin
        serial_out = par_bit_reg;
        busy       = 1'b1;
      end
`endif
      default: begin
        serial_out = IDLE_VAL;
        busy       = 1'b0;
      end
    endcase
  end

  assign done = done_reg;

endmodule

// File: tb/tb_flex_pts_tx.sv
// Bench for flex_pts_tx: an MSB-first and an LSB-first instance share the
// same stimulus. Stimulus pushes the expected line bits of every loaded
// word into one queue per instance; a monitor pops and compares a bit each
// time a strobe consumes one.
module tb_flex_pts_tx;

  localparam int NB = 8;
`ifdef FLEX_PTS_TX_PARITY_EN
  localparam int FL = NB + 1;
`else
  localparam int FL = NB;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          shift_enable;
  logic [NB-1:0] parallel_in;
  logic          load_valid;
  logic          load_ready_m, serial_out_m, busy_m, done_m;
  logic          load_ready_l, serial_out_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;
  int done_cnt_m = 0;
  int done_cnt_l = 0;
  int exp_done = 0;
  logic exp_m[$];
  logic exp_l[$];

  always #5 clk = ~clk;

  flex_pts_tx #(.NUM_BITS(NB), .SHIFT_MSB(1'b1), .IDLE_VAL(1'b1)) u_msb (
    .clk(clk), .rst(rst), .shift_enable(shift_enable),
    .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(load_ready_m), .serial_out(serial_out_m),
    .busy(busy_m), .done(done_m)
  );

  flex_pts_tx #(.NUM_BITS(NB), .SHIFT_MSB(1'b0), .IDLE_VAL(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .shift_enable(shift_enable),
    .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(load_ready_l), .serial_out(serial_out_l),
    .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [NB-1:0] w);
    for (int i = NB - 1; i >= 0; i--) exp_m.push_back(w[i]);
    for (int i = 0; i < NB; i++) exp_l.push_back(w[i]);
`ifdef FLEX_PTS_TX_PARITY_EN
    exp_m.push_back(^w);
    exp_l.push_back(^w);
`endif
  endtask

  task automatic load(input logic [NB-1:0] w);
    parallel_in = w;
    load_valid  = 1'b1;
    push_exp(w);
    tick();
    load_valid  = 1'b0;
    parallel_in = ~w;   // must not affect the frame in flight
    $display("load word %02h", w);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      shift_enable = 1'b1;
      tick();
    end
    shift_enable = 1'b0;
  endtask

  task automatic frame_done(input string tag);
    chk({tag, "_done_m"}, done_m, 1'b1);
    chk({tag, "_done_l"}, done_l, 1'b1);
    exp_done++;
    $display("frame %s complete", tag);
  endtask

  // Monitor: compare every bit consumed by a strobe, count done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (shift_enable && busy_m) begin
        if (exp_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL bit_msb: got %0b expected none (queue empty)", serial_out_m);
        end else begin
          chk("bit_msb", serial_out_m, exp_m.pop_front());
        end
      end
      if (shift_enable && busy_l) begin
        if (exp_l.size() == 0) begin
          checks++; errors++;
          $display("FAIL bit_lsb: got %0b expected none (queue empty)", serial_out_l);
        end else begin
          chk("bit_lsb", serial_out_l, exp_l.pop_front());
        end
      end
      if (done_m) done_cnt_m++;
      if (done_l) done_cnt_l++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    shift_enable = 1'b0;
    parallel_in  = '0;
    load_valid   = 1'b0;
    #2;
    chk("rst_ready", load_ready_m, 1'b0);
    chk("rst_serial", serial_out_m, 1'b1);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_done", done_m, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", load_ready_m, 1'b1);

    // Frame 0xA5
    load(8'hA5);
    chk("a5_busy", busy_m, 1'b1);
    chk("a5_first_bit", serial_out_m, 1'b1);
    run(FL);
    frame_done("a5");
    chk("a5_busy_end", busy_m, 1'b0);
    chk("a5_idle_line", serial_out_m, 1'b1);
    tick();
    chk("a5_done_once", done_m, 1'b0);

    // Frame 0x0F with a 3-cycle strobe gap, then 0xF0 loaded back-to-back
    load(8'h0F);
    run(3);
    for (int i = 0; i < 3; i++) begin
      chk("hold_msb", serial_out_m, 1'b0);
      chk("hold_lsb", serial_out_l, 1'b1);
      chk("hold_busy", busy_m, 1'b1);
      tick();
    end
    run(FL - 4);
    shift_enable = 1'b1;
    load_valid   = 1'b1;
    parallel_in  = 8'hF0;
    push_exp(8'hF0);
    #1;
    chk("b2b_ready", load_ready_m, 1'b1);
    tick();
    load_valid   = 1'b0;
    shift_enable = 1'b0;
    $display("load word f0 (back-to-back)");
    frame_done("0f");
    chk("b2b_busy", busy_m, 1'b1);
    chk("b2b_first_bit", serial_out_m, 1'b1);

    // 0xFF offered mid-frame must be ignored
    run(3);
    shift_enable = 1'b1;
    load_valid   = 1'b1;
    parallel_in  = 8'hFF;
    #1;
    chk("midframe_ready", load_ready_m, 1'b0);
    tick();
    load_valid = 1'b0;
    run(FL - 4);
    frame_done("f0");
    chk("f0_busy_end", busy_m, 1'b0);
    tick();

    // Reset at bit 4 aborts the frame without a done pulse
    load(8'h3C);
    run(4);
    rst = 1'b1;
    #1;
    chk("abort_serial", serial_out_m, 1'b1);
    chk("abort_busy", busy_m, 1'b0);
    chk("abort_ready", load_ready_m, 1'b0);
    exp_m.delete();
    exp_l.delete();
    $display("frame 3c aborted by reset");
    tick();
    chk("abort_no_done", done_m, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", load_ready_m, 1'b1);
    load(8'h81);
    run(FL);
    frame_done("81");
    tick();

    chk("done_count_m", done_cnt_m, exp_done);
    chk("done_count_l", done_cnt_l, exp_done);
    chk("queue_empty_m", exp_m.size(), 0);
    chk("queue_empty_l", exp_l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flex_pts_tx.md
# flex_pts_tx

Parametrised parallel-to-serial transmitter; the framed successor to the flex PTS shift register. Accepts a parallel word through a valid/ready handshake and shifts it out one bit per `shift_enable` strobe, MSB- or LSB-first. A bit counter tracks frame progress, a `done` pulse marks each completed frame, and a word can be loaded back-to-back on the final bit. Sits between a word-level producer (FIFO or controller) and a bit-rate timer that generates `shift_enable`.

## Interface
- `NUM_BITS`, 8, data word width; legal range 2–32.
- `SHIFT_MSB`, 1, 1 = MSB first, 0 = LSB first.
- `IDLE_VAL`, 1'b1, line level driven when idle; also the fill bit shifted in.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `shift_enable`  input  1  bit strobe; one bit is consumed per cycle it is high.
- `parallel_in`  input  NUM_BITS  word to transmit.
- `load_valid`  input  1  producer has a word on `parallel_in`.
- `load_ready`  output  1  block accepts a word this cycle.
- `serial_out`  output  1  current line bit.
- `busy`  output  1  a frame is in progress.
- `done`  output  1  one-cycle pulse after a frame's last bit is consumed.

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro defined).
- Registers: `shreg[NUM_BITS-1:0]`, `bit_cnt` ($clog2(NUM_BITS) bits), `par_bit`, `state`, `done`.
- Accept = `load_valid & load_ready`.
- `load_ready` = (state == IDLE) | last_strobe, where last_strobe = `shift_enable` & final bit of frame (SHIFT with `bit_cnt == NUM_BITS-1` and no parity; PARITY otherwise). Forced to 0 while `rst` is high.
- IDLE: `serial_out = IDLE_VAL`, `busy = 0`, `shift_enable` ignored. On accept: `shreg <= parallel_in`, `bit_cnt <= 0`, `par_bit <= ^parallel_in`, go to SHIFT.
- SHIFT: `serial_out = shreg[NUM_BITS-1]` if `SHIFT_MSB`, else `shreg[0]`. On `shift_enable`:
  - shift toward the output end, fill with `IDLE_VAL`;
  - `bit_cnt++`.
- At `bit_cnt == NUM_BITS-1` with `shift_enable`: go to PARITY (macro defined) or end the frame.
- PARITY: `serial_out = par_bit`. On `shift_enable`, end the frame.
- End of frame: `done <= 1` for one cycle. If accept occurs in the same cycle, reload and return to SHIFT with `bit_cnt = 0`; otherwise go to IDLE.
- `busy` = state != IDLE.
- `load_valid` while `load_ready` is 0 is ignored; the word is not captured and no error is flagged.
- `parallel_in` is sampled only on accept; changes mid-frame have no effect.
- `bit_cnt` never wraps past `NUM_BITS-1`.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, `shreg = {NUM_BITS{IDLE_VAL}}`, `bit_cnt = 0`, `par_bit = 0`;
  - `serial_out = IDLE_VAL`, `busy = 0`, `done = 0`, `load_ready = 0`;
  - `load_ready = 1` from the first cycle after release.
- Reset mid-frame aborts the frame with no `done` pulse.
- Accept at edge N: first data bit appears on `serial_out` after edge N. Zero added latency beyond the register.
- Each bit is held until the edge at which `shift_enable` is sampled high.
- A frame consumes exactly NUM_BITS strobes, or NUM_BITS+1 with parity.
- `done` is high for the single cycle following the edge that consumed the final bit.
- Back-to-back: on a reloading end-of-frame edge, the next word's first bit appears with no idle gap, and `done` still pulses.
- `serial_out`, `busy` and `done` depend on registers only. `load_ready` depends combinationally on `shift_enable`.

## Configuration
- `FLEX_PTS_TX_PARITY_EN`:
  - Defined: PARITY state compiled in. An even-parity bit (`^data`) is sent after the data bits, and frames are NUM_BITS+1 bits long.
  - Undefined: no PARITY state, no `par_bit` register, and frames are NUM_BITS bits long.

## Test plan
- NUM_BITS=8, SHIFT_MSB=1, IDLE_VAL=1, no parity. Load 0xA5, then 8 strobes → `serial_out` 1,0,1,0,0,1,0,1, then 1 (idle). `done` pulses once, `busy` is high for exactly the frame.
- SHIFT_MSB=0. Load 0x0F → `serial_out` 1,1,1,1,0,0,0,0. `shift_enable` held low 3 cycles mid-frame → bit held, count unchanged.
- Parity defined. Load 0x07 → 8 data bits (MSB first) then 1. Load 0x03 → parity bit 0. Frame is 9 strobes, `done` after the ninth.
- Back-to-back. `load_valid` high with 0xF0 during the last strobe of 0x0F → no idle bit between frames, 16 strobes total, two `done` pulses.
- `load_valid` with 0xFF at bit 3 of a frame → ignored (`load_ready=0`); the current frame completes unchanged.
- Assert `rst` at bit 4 → `serial_out=1` and `busy=0` immediately, no `done`. After release, `load_ready=1` and a new load of 0x81 transmits correctly.
